// File: rtl/snake_direction_control.sv
// Debounced push-button to one-hot snake direction; requests commit only on game_tick.
// Optional build macro DIR_REVERSE_GUARD_EN rejects 180-degree reversals.
module snake_direction_control #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] keys,
  input  logic       game_tick,
  output logic [3:0] direction,
  output logic       pending_valid,
  output logic       dir_changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_t;

  function automatic logic [3:0] reverse_dir(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  logic [3:0] sync1_r, sync2_r, pressed_s, press_ev_s, event_r;
  logic [3:0] event_sel_s, ref_dir_s, pending_r;
  logic [3:0] direction_s, pending_s;
  logic       commit_s, accept_s, guard_ok_s, pending_valid_s;

  // Two-flop synchroniser; idle level is released (high).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_r <= 4'hF;
      sync2_r <= 4'hF;
    end else begin
      sync1_r <= keys;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = ~sync2_r;

  for (genvar g = 0; g < 4; g++) begin : g_key
    deb_state_t    state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          press_s;

    // Debounce state and counter register.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        state_r <= RELEASED;
        cnt_r   <= CNT_ZERO;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
      end
    end

    // Debounce next-state; the counter stops at its last value rather than wrapping.
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      press_s = 1'b0;
      case (state_r)
        RELEASED: begin
          if (pressed_s[g]) begin
            state_s = PRESS_WAIT;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = RELEASED;
          end
        end
        PRESS_WAIT: begin
          if (!pressed_s[g]) begin
            state_s = RELEASED;
          end else if (cnt_r == CNT_LAST) begin
            state_s = HELD;
            press_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        HELD: begin
          if (!pressed_s[g]) begin
            state_s = RELEASE_WAIT;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = HELD;
          end
        end
        RELEASE_WAIT: begin
          if (pressed_s[g]) begin
            state_s = HELD;
          end else if (cnt_r == CNT_LAST) begin
            state_s = RELEASED;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = RELEASED;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end

    assign press_ev_s[g] = press_s;
  end

  // Register press events so they arrive one cycle after the FSM accepts the key.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) event_r <= 4'b0000;
    else         event_r <= press_ev_s;
  end

  // Fixed priority DOWN > UP > RIGHT > LEFT.
  always_comb begin
    event_sel_s = 4'b0000;
    if      (event_r[0]) event_sel_s = 4'b0001;
    else if (event_r[1]) event_sel_s = 4'b0010;
    else if (event_r[2]) event_sel_s = 4'b0100;
    else if (event_r[3]) event_sel_s = 4'b1000;
    else                 event_sel_s = 4'b0000;
  end

  assign commit_s  = game_tick & pending_valid;
  // A new event is filtered against the value that will be committed after this edge.
  assign ref_dir_s = commit_s ? pending_r : direction;
`ifdef DIR_REVERSE_GUARD_EN
  assign guard_ok_s = (event_sel_s != reverse_dir(ref_dir_s));
`else
  assign guard_ok_s = 1'b1;
`endif
  assign accept_s = (event_sel_s != 4'b0000) && (event_sel_s != ref_dir_s) && guard_ok_s;

  // Commit / pending next-state.
  always_comb begin
    direction_s     = direction;
    pending_s       = pending_r;
    pending_valid_s = pending_valid;
    if (commit_s) begin
      direction_s     = pending_r;
      pending_valid_s = 1'b0;
    end else begin
      direction_s = direction;
    end
    if (accept_s) begin
      pending_s       = event_sel_s;
      pending_valid_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
  end

  // Output and pending registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      direction     <= 4'b0001;
      pending_r     <= 4'b0001;
      pending_valid <= 1'b0;
      dir_changed   <= 1'b0;
    end else begin
      direction     <= direction_s;
      pending_r     <= pending_s;
      pending_valid <= pending_valid_s;
      dir_changed   <= commit_s;
    end
  end

endmodule

// File: tb/tb_snake_direction_control.sv
// Randomised self-checking bench for snake_direction_control with a run-length debounce model.
module tb_snake_direction_control;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] keys = 4'hF;
  logic       game_tick = 1'b0;
  logic [3:0] direction;
  logic       pending_valid;
  logic       dir_changed;

  int n_checks = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  snake_direction_control #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .resetn(resetn), .keys(keys), .game_tick(game_tick),
    .direction(direction), .pending_valid(pending_valid), .dir_changed(dir_changed)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [3:0] m_pipe [2];
  logic [3:0] m_acc, m_ev, m_dir, m_pend;
  logic       m_pv, m_chg;
  int         m_run [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit is_reverse(input logic [3:0] a, input logic [3:0] b);
    return (a == 4'd1 && b == 4'd2) || (a == 4'd2 && b == 4'd1) ||
           (a == 4'd4 && b == 4'd8) || (a == 4'd8 && b == 4'd4);
  endfunction

  // Model: a key level is accepted after D+1 consecutive opposite synchronised samples.
  always @(posedge clock or negedge resetn) begin : model
    logic [3:0] ev, refd, rise;
    logic       ok, pr;
    if (!resetn) begin
      m_pipe[0] <= 4'hF; m_pipe[1] <= 4'hF;
      m_acc <= 4'h0; m_ev <= 4'h0; m_dir <= 4'b0001; m_pend <= 4'b0001;
      m_pv <= 1'b0; m_chg <= 1'b0;
      for (int k = 0; k < 4; k++) m_run[k] <= 0;
    end else begin
      ev = 4'h0;
      for (int k = 3; k >= 0; k--) if (m_ev[k]) ev = 4'b0001 << k;
      refd = (game_tick && m_pv) ? m_pend : m_dir;
      ok = (ev != 4'h0) && (ev != refd);
`ifdef DIR_REVERSE_GUARD_EN
      if (is_reverse(ev, refd)) ok = 1'b0;
`endif
      m_chg <= game_tick && m_pv;
      if (game_tick && m_pv) m_dir <= m_pend;
      if (ok) begin
        m_pend <= ev;
        m_pv <= 1'b1;
      end else if (game_tick && m_pv) begin
        m_pv <= 1'b0;
      end
      rise = 4'h0;
      for (int k = 0; k < 4; k++) begin
        pr = ~m_pipe[1][k];
        if (pr != m_acc[k]) begin
          if (m_run[k] == D) begin
            m_acc[k] <= pr;
            m_run[k] <= 0;
            rise[k] = pr;
          end else begin
            m_run[k] <= m_run[k] + 1;
          end
        end else begin
          m_run[k] <= 0;
        end
      end
      m_ev <= rise;
      m_pipe[1] <= m_pipe[0];
      m_pipe[0] <= keys;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (checking) begin
      chk("direction", {28'd0, direction}, {28'd0, m_dir});
      chk("pending_valid", {31'd0, pending_valid}, {31'd0, m_pv});
      chk("dir_changed", {31'd0, dir_changed}, {31'd0, m_chg});
      chk("onehot", {31'd0, $onehot(direction)}, 32'd1);
    end
  end

  task automatic cyc(input logic [3:0] k, input logic t);
    @(negedge clock);
    keys = k;
    game_tick = t;
    @(posedge clock);
    #1;
  endtask

  task automatic cycn(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) cyc(k, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    resetn = 1'b0;
    keys = 4'hF;
    game_tick = 1'b0;
    @(negedge clock);
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    logic [3:0] rk;
    @(posedge clock);
    #1;
    checking = 1'b1;
    do_reset();

    // T1: idle ticks change nothing
    chk("t1_reset_dir", {28'd0, direction}, 32'd1);
    chk("t1_reset_pv", {31'd0, pending_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(4'hF, 1'b1);
      chk("t1_no_change", {31'd0, dir_changed}, 32'd0);
    end
    chk("t1_dir", {28'd0, direction}, 32'd1);

    // T2: press latency and commit
    cyc(4'b1011, 1'b0);
    cycn(4'b1011, 6);
    chk("t2_pv_edge6", {31'd0, pending_valid}, 32'd0);
    cyc(4'b1011, 1'b0);
    chk("t2_pv_edge7", {31'd0, pending_valid}, 32'd1);
    cycn(4'b1011, 2);
    cyc(4'b1011, 1'b1);
    chk("t2_dir", {28'd0, direction}, 32'h4);
    chk("t2_chg", {31'd0, dir_changed}, 32'd1);
    cyc(4'b1011, 1'b0);
    chk("t2_chg_fall", {31'd0, dir_changed}, 32'd0);
    cyc(4'b1011, 1'b1);
    chk("t2_hold_dir", {28'd0, direction}, 32'h4);
    chk("t2_hold_chg", {31'd0, dir_changed}, 32'd0);
    cycn(4'hF, 12);

    // T3: bounce rejection
    cycn(4'b1101, 2); cycn(4'hF, 1); cycn(4'b1101, 2); cycn(4'hF, 10);
    chk("t3_pv", {31'd0, pending_valid}, 32'd0);

    // T4: reversal from DOWN
    do_reset();
    cycn(4'b1101, 10); cycn(4'hF, 10);
    cyc(4'hF, 1'b1);
`ifdef DIR_REVERSE_GUARD_EN
    chk("t4_dir", {28'd0, direction}, 32'h1);
    chk("t4_pv", {31'd0, pending_valid}, 32'd0);
`else
    chk("t4_dir", {28'd0, direction}, 32'h2);
`endif

    // T5: last press wins
    do_reset();
    cycn(4'b0111, 10); cycn(4'hF, 10); cycn(4'b1011, 10); cycn(4'hF, 10);
    cyc(4'hF, 1'b1);
    chk("t5_dir", {28'd0, direction}, 32'h4);

    // T6: event and tick in the same cycle, then reset while pending
    do_reset();
    cycn(4'b1011, 10); cycn(4'hF, 10);
    cycn(4'b1101, 7);
    cyc(4'b1101, 1'b1);
    chk("t6_dir", {28'd0, direction}, 32'h4);
    chk("t6_pv", {31'd0, pending_valid}, 32'd1);
    cycn(4'hF, 8);
    cyc(4'hF, 1'b1);
    chk("t6_dir_up", {28'd0, direction}, 32'h2);
    cycn(4'b0111, 10);
    chk("t6_pv_left", {31'd0, pending_valid}, 32'd1);
    @(negedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_dir", {28'd0, direction}, 32'h1);
    chk("t6_rst_pv", {31'd0, pending_valid}, 32'd0);
    @(negedge clock);
    #2;
    resetn = 1'b1;

    // Random phase: slowly toggling bouncy keys, random ticks, rare resets
    rk = 4'hF;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 11) == 0) rk[k] = ~rk[k];
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        rk = 4'hF;
      end else begin
        cyc(rk, ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
      end
    end

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
